// File: rtl/aes_pkg.sv
// Shared AES decryption datapath definitions: widths, FSM state codes and byte packing helper.
package aes_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned STATE_W   = 128;
    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned OFF_W     = 7;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // Byte 0 sits in the most significant byte of the state word.
    function automatic logic [OFF_W-1:0] byte_lsb(input int unsigned idx);
        return OFF_W'((NUM_BYTES - 1 - idx) * BYTE_W);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 table), one byte in, one byte out.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] val,
    output logic [BYTE_W-1:0] inv_c
);

    localparam logic [0:255][BYTE_W-1:0] INV_SBOX_TAB = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign inv_c = INV_SBOX_TAB[val];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes LANES bytes per cycle of one buffered AES state,
// then holds the result until AddRoundKey takes it.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    localparam int unsigned BEATS = NUM_BYTES / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    fsm_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic [BYTE_W-1:0]  lane_in  [LANES];
    logic [BYTE_W-1:0]  lane_out [LANES];

    // Lane k works on byte cnt*LANES+k of the current group.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_in[k] = work_q[byte_lsb(32'(cnt_q) * LANES + k) +: BYTE_W];
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .val   (lane_in[g]),
            .inv_c (lane_out[g])
        );
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign state_out = work_q;

    // Next-state, counter and working-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = state_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    work_d[byte_lsb(32'(cnt_q) * LANES + k) +: BYTE_W] = lane_out[k];
                end
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = state_in;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            out_valid <= (state_d == ST_DONE);
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: inverse S-box derived from GF(2^8) arithmetic,
// expected states queued on accept and compared by a monitor on each output handshake.
module tb_inv_sub_bytes_iter;

    localparam int unsigned LANES = 4;
    localparam int unsigned BEATS = 16 / LANES;

    logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] state_in, state_out;

    int unsigned  checks, passes;
    int           cyc;
    bit           done, rand_ready, ready_force;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           out_cyc_q[$];
    logic [7:0]   inv_tab[256];

    inv_sub_bytes_iter #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b = 8'h00;
        logic [7:0] r, s;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
            end
        end
        s = b;
        r = b;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st);
        logic [127:0] o = st;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_tab[st[127 - 8*i -: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge, in_valid still high.
    task automatic send(input logic [127:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        state_in = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        state_in = rnd128();
    endtask

    task automatic wait_out(output logic [127:0] d);
        bit ok = 1'b0;
        d = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                d  = state_out;
            end
        end
        if (!ok) chk("out_valid_timeout", 128'(0), 128'(1));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [127:0] res;
        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
        checks = 0; passes = 0; cyc = 0; done = 1'b0;
        rst = 1'b1; in_valid = 1'b0; state_in = '0;
        out_ready = 1'b1; ready_force = 1'b1; rand_ready = 1'b0;

        fork
            while (!done) begin
                @(posedge clk);
                cyc++;
            end

            while (!done) begin
                @(posedge clk);
                #1;
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
            end

            begin : monitor
                bit prev_ov = 1'b0, prev_or = 1'b0;
                logic [127:0] prev_data = '0;
                int a;
                while (!done) begin
                    @(negedge clk);
                    if (rst) begin
                        prev_ov = 1'b0;
                    end else begin
                        if (in_valid && in_ready) begin
                            exp_q.push_back(model(state_in));
                            acc_q.push_back(cyc + 1);
                        end
                        if (out_valid && !prev_ov) begin
                            if (acc_q.size() == 0) chk("unexpected_out_valid", 128'(1), 128'(0));
                            else begin
                                a = acc_q.pop_front();
                                chk("latency", 128'(cyc - a), 128'(BEATS));
                            end
                        end
                        if (out_valid && prev_ov && !prev_or) chk("hold_stable", state_out, prev_data);
                        if (out_valid && out_ready) begin
                            if (exp_q.size() == 0) chk("extra_output", 128'(1), 128'(0));
                            else chk("data", state_out, exp_q.pop_front());
                            out_cyc_q.push_back(cyc + 1);
                        end
                        prev_ov   = out_valid;
                        prev_or   = out_ready;
                        prev_data = state_out;
                    end
                end
            end

            begin : driver
                int t0;
                cycles(2);
                chk("reset_out_valid", 128'(out_valid), 128'(0));
                chk("reset_in_ready", 128'(in_ready), 128'(1));
                chk("reset_busy", 128'(busy), 128'(0));
                rst = 1'b0;
                cycles(1);

                // FIPS-197 C.1 round 1 known answer
                send(128'h7a9f102789d5f50b2beffd9f3dca4ea7);
                idle();
                chk("busy_in_run", 128'(busy), 128'(1));
                wait_out(res);
                chk("kat_c1", res, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
                cycles(2);

                // S-box corner bytes
                send({40'h000163ff53, 88'h0});
                idle();
                wait_out(res);
                chk("kat_corners", res, {40'h5209007d50, {11{8'h52}}});
                cycles(2);

                // Backpressure: hold out_ready low, in_valid asserted but must be ignored
                ready_force = 1'b0;
                cycles(2);
                send(rnd128());
                idle();
                wait_out(res);
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b1;
                    state_in = rnd128();
                    @(negedge clk);
                    chk("bp_in_ready", 128'(in_ready), 128'(0));
                    chk("bp_out_valid", 128'(out_valid), 128'(1));
                end
                @(posedge clk);
                #1;
                idle();
                ready_force = 1'b1;
                begin
                    bit hs = 1'b0;
                    for (int i = 0; i < 10 && !hs; i++) begin
                        @(negedge clk);
                        if (out_valid && out_ready) hs = 1'b1;
                    end
                    chk("bp_release", 128'(hs), 128'(1));
                    @(negedge clk);
                    chk("bp_drop", 128'(out_valid), 128'(0));
                end
                cycles(2);

                // Back-to-back with continuous out_ready
                out_cyc_q.delete();
                send({16{8'h63}});
                send({16{8'h00}});
                idle();
                t0 = 0;
                while (out_cyc_q.size() < 2 && t0 < 40) begin
                    @(negedge clk);
                    t0++;
                end
                if (out_cyc_q.size() < 2) chk("b2b_timeout", 128'(out_cyc_q.size()), 128'(2));
                else chk("b2b_spacing", 128'(out_cyc_q[1] - out_cyc_q[0]), 128'(BEATS + 1));
                cycles(2);

                // Reset two cycles after accept discards the block
                send({16{8'h63}});
                idle();
                @(posedge clk);
                @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                chk("rst_out_valid", 128'(out_valid), 128'(0));
                chk("rst_in_ready", 128'(in_ready), 128'(1));
                chk("rst_busy", 128'(busy), 128'(0));
                exp_q.delete();
                acc_q.delete();
                cycles(2);
                rst = 1'b0;
                cycles(6);
                send({16{8'h63}});
                idle();
                wait_out(res);
                chk("post_rst_block", res, {16{8'h00}});
                cycles(2);

                // Random traffic with random backpressure
                rand_ready = 1'b1;
                for (int n = 0; n < 30; n++) begin
                    cycles($urandom_range(0, 3));
                    send(rnd128());
                    if ($urandom_range(0, 1) == 1) idle();
                end
                idle();
                rand_ready = 1'b0;
                ready_force = 1'b1;
                t0 = 0;
                while ((exp_q.size() != 0 || in_valid) && t0 < 200) begin
                    cycles(1);
                    t0++;
                end
                cycles(3);
                chk("drain_empty", 128'(exp_q.size()), 128'(0));
                done = 1'b1;
            end
        join

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
Iterative InvSubBytes stage for the AES-128 decryption datapath. It sits directly downstream of the inverse ShiftRows stage. It accepts one 128-bit state via valid/ready handshake and substitutes LANES bytes per clock through LANES inverse S-box instances. The substituted state is presented to the next stage (AddRoundKey) through its own valid/ready handshake. It trades latency (16/LANES cycles) for S-box area.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (must divide 16).
BEATS, 16/LANES, derived localparam: RUN cycles per block. Not overridable.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  state_in holds a valid state.
in_ready  out  1  block can accept a state this cycle.
state_in  in  128  input state, byte i at [127-8i -: 8], column-major AES order.
out_valid  out  1  state_out holds the fully substituted state.
out_ready  in  1  downstream accepts state_out this cycle.
state_out  out  128  substituted state, same byte packing as state_in.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset is asynchronous and active-high (rst); a single clock, clk. Reset sets FSM=IDLE, beat counter=0, working register=0, out_valid=0, busy=0, in_ready=1. A reset mid-RUN or mid-DONE discards the block; no output is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, load state_in into the working register, set cnt=0, go to RUN.
  - RUN: in_ready=0. Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register are replaced by InvSbox(byte). cnt increments. When cnt==BEATS-1, the last group is written, cnt wraps to 0, and the FSM goes to DONE.
  - DONE: out_valid=1. state_out equals the working register and must stay stable while out_valid&&!out_ready. On out_ready the FSM leaves DONE.
- Back-to-back: in_ready = (FSM==IDLE) || (FSM==DONE && out_ready).
  - If DONE, out_ready and in_valid are all high in the same cycle, the output handshake completes and the new state loads; the next state is RUN.
  - If DONE and out_ready are high but in_valid is low, the next state is IDLE.
- Latency: accept on edge E0; out_valid rises after edge E(BEATS), i.e. E4 for LANES=4.
  - Throughput is one block per BEATS+1 cycles with continuous out_ready, because DONE occupies one cycle.
  - For LANES=16 there is one RUN cycle.
- state_out is driven from the working register in all states. It is only meaningful when out_valid=1, and the bench must not check it otherwise.
- in_valid while in_ready=0 is ignored; the upstream stage must hold its data.
- Purely byte-wise: there is no cross-byte arithmetic. Byte ordering and packing are unchanged.

Decomposition:
- Shared package aes_pkg: BYTE_W=8, STATE_W=128, NUM_BYTES=16, and the FSM state enum {IDLE, RUN, DONE}. Later iterative stages (inv_mix_columns_iter, add_round_key) reuse it.
- Sub-module inv_sbox: combinational 8-bit in, 8-bit out, full 256-entry FIPS-197 inverse S-box lookup. It is instantiated LANES times, and lane k is fed byte cnt*LANES+k via a mux.

Test Plan:
- Reset then idle: assert rst mid-simulation with no clk edge -> out_valid=0, in_ready=1, busy=0 immediately after rst rises.
- Single block, LANES=4:
  - Stimulus: state_in=7a9f102789d5f50b2beffd9f3dca4ea7 with out_ready=1.
  - Expected: out_valid high exactly 4 edges after accept, with state_out=bd6e7c3df2b5779e0b61216e8b10b689 (FIPS-197 C.1 round 1).
- S-box corners:
  - Stimulus: state_in=000163ff53... with remaining bytes 00.
  - Expected: state_out bytes 52,09,00,7d,50, and remaining bytes 52.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> state_out stable, in_ready=0 and in_valid ignored throughout. Releasing out_ready completes the handshake once, and out_valid drops the next cycle.
- Back-to-back:
  - Stimulus: in_valid held high with out_ready=1, feeding all-63 then all-00 states.
  - Expected: outputs all-00 then all-52, spaced 5 cycles apart, in order, with no dropped or duplicated block.
- Reset mid-RUN: assert rst two cycles after accept -> out_valid never rises for that block. After release, a new all-63 block yields all-00 with normal latency.
